// File: rtl/sum_tree_feeder.sv
// ---------------------------------------------------------------------------
// sum_tree_feeder
//
// Front-end and result collector for an external N-input pipelined adder tree
// with TREE_LAT register stages. Operand words arrive over a valid/ready
// handshake and are packed into an N-entry vector that drives the tree's
// sum64 inputs. While the tree's latency elapses the vector is frozen. The
// tree result is then captured and offered on a valid/ready output.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   in_valid     - operand word valid
//   in_ready     - feeder accepts a word (high only in FILL)
//   in_data      - operand word
//   in_last      - closes a short batch (only with FEEDER_ZERO_PAD_EN)
//   vec_out      - registered operand vector to the tree
//   tree_result  - tree sum output
//   out_valid    - captured sum available
//   out_ready    - consumer accepts the sum
//   out_data     - captured sum
//   out_count    - number of words in the batch behind out_data
//
// Configuration macro:
//   FEEDER_ZERO_PAD_EN - when defined, in_last closes a batch of 1..N words;
//                        unwritten entries stay zero from the post-batch
//                        clear. When undefined, every batch is N words and
//                        in_last is ignored.
// ---------------------------------------------------------------------------
module sum_tree_feeder #(
    parameter int WIDTH    = 128,
    parameter int N        = 64,
    parameter int TREE_LAT = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_last,
    output logic [WIDTH-1:0]   vec_out [0:N-1],
    input  logic [WIDTH-1:0]   tree_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [$clog2(N):0] out_count
);

    localparam int CNT_W  = $clog2(N) + 1;
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int WAIT_W = (TREE_LAT > 0) ? $clog2(TREE_LAT + 1) : 1;

    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(N - 1);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(TREE_LAT);

    typedef enum logic [1:0] {
        FILL,
        WAIT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [WIDTH-1:0]   vec_q [0:N-1];
    logic [WIDTH-1:0]   vec_d [0:N-1];
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;

    logic               batch_last;
    logic               batch_close;

`ifdef FEEDER_ZERO_PAD_EN
    assign batch_last = in_last;
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign batch_last     = 1'b0;
`endif

    // A batch closes on the N-th word, or early on a flagged last word.
    assign batch_close = (idx_q == LAST_IDX) || batch_last;

    assign in_ready  = (state_q == FILL);
    assign vec_out   = vec_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wait_cnt_d  = wait_cnt_q;
        vec_d       = vec_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;

        case (state_q)
            FILL: begin
                if (in_valid) begin
                    vec_d[idx_q[IDX_W-1:0]] = in_data;
                    idx_d                   = idx_q + 1'b1;
                    if (batch_close) begin
                        out_count_d = idx_q + 1'b1;
                        wait_cnt_d  = WAIT_INIT;
                        state_d     = WAIT;
                    end
                end
            end

            // The counter is loaded with TREE_LAT and the capture happens
            // on the edge after it reaches zero, so out_valid rises
            // TREE_LAT+1 edges after the closing accept.
            WAIT: begin
                if (wait_cnt_q == '0) begin
                    out_data_d  = tree_result;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end

            // Clearing the vector here lets a short batch rely on zeros in
            // its unwritten entries.
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    idx_d       = '0;
                    state_d     = FILL;
                    for (int i = 0; i < N; i++) begin
                        vec_d[i] = '0;
                    end
                end
            end

            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            idx_q       <= '0;
            wait_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            for (int i = 0; i < N; i++) begin
                vec_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wait_cnt_q  <= wait_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            for (int i = 0; i < N; i++) begin
                vec_q[i] <= vec_d[i];
            end
        end
    end

endmodule

// File: tb/tb_sum_tree_feeder.sv
// ---------------------------------------------------------------------------
// tb_sum_tree_feeder
//
// Bench for sum_tree_feeder. A small behavioural adder tree (TREE_LAT
// register stages, reset by rst_n) closes the loop from vec_out back to
// tree_result. Full-batch cases come from a table of directed vectors; the
// backpressure, short-batch and reset-mid-WAIT cases are hand-written.
// ---------------------------------------------------------------------------
module tb_sum_tree_feeder;

    localparam int WIDTH    = 128;
    localparam int N        = 64;
    localparam int TREE_LAT = 6;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_last   = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] in_data   = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] tree_result;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] vec_out [0:N-1];
    logic [6:0]       out_count;

    logic [WIDTH-1:0] tree_pipe [0:TREE_LAT-1];

    int cycle  = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int               kind;
        logic [WIDTH-1:0] value;
        logic [WIDTH-1:0] exp_data;
        logic [6:0]       exp_count;
    } vec_t;

    vec_t vecs [0:4];

    sum_tree_feeder #(
        .WIDTH    (WIDTH),
        .N        (N),
        .TREE_LAT (TREE_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .vec_out     (vec_out),
        .tree_result (tree_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_count   (out_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [WIDTH-1:0] sum_vec();
        logic [WIDTH-1:0] s;
        s = '0;
        for (int i = 0; i < N; i++) s += vec_out[i];
        return s;
    endfunction

    // Behavioural tree: stage 0 samples the vector, the last stage is result.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TREE_LAT; k++) tree_pipe[k] <= '0;
        end else begin
            tree_pipe[0] <= sum_vec();
            for (int k = 1; k < TREE_LAT; k++) tree_pipe[k] <= tree_pipe[k-1];
        end
    end

    assign tree_result = tree_pipe[TREE_LAT-1];

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic last,
                                 output int accept_cycle);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        while (!in_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("accept_ready", WIDTH'(in_ready), WIDTH'(1));
        if (in_ready) begin
            @(posedge clk); #1;
        end
        accept_cycle = cycle;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic sendBatch(input int kind, input logic [WIDTH-1:0] value, input int count,
                             input bit last_on_final, output int last_accept);
        logic [WIDTH-1:0] data;
        last_accept = cycle;
        for (int i = 0; i < count; i++) begin
            data = (kind == 1) ? WIDTH'(i) : value;
            applyStimulus(data, last_on_final && (i == count - 1), last_accept);
        end
    endtask

    task automatic waitOutValid(output int seen);
        int waited;
        waited = 0;
        while (!out_valid && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("out_valid_timeout", WIDTH'(out_valid), WIDTH'(1));
        seen = cycle;
    endtask

    // Expects out_ready already high so the handshake follows immediately.
    task automatic finishBatch(input string name, input int accept_cycle,
                               input logic [WIDTH-1:0] exp_data, input logic [6:0] exp_count);
        int seen;
        waitOutValid(seen);
        checkOutput({name, "_latency"}, WIDTH'(seen - accept_cycle), WIDTH'(7));
        checkOutput({name, "_data"}, out_data, exp_data);
        checkOutput({name, "_count"}, WIDTH'(out_count), WIDTH'(exp_count));
        checkOutput({name, "_in_ready_busy"}, WIDTH'(in_ready), WIDTH'(0));
        @(posedge clk); #1;
        checkOutput({name, "_valid_drop"}, WIDTH'(out_valid), WIDTH'(0));
        checkOutput({name, "_in_ready_back"}, WIDTH'(in_ready), WIDTH'(1));
        checkOutput({name, "_clear"}, vec_out[N-1], WIDTH'(0));
    endtask

    initial begin
        int acc;
        int seen;
        int spurious;

        vecs[0] = '{kind: 0, value: 128'd1, exp_data: 128'd64, exp_count: 7'd64};
        vecs[1] = '{kind: 1, value: 128'd0, exp_data: 128'd2016, exp_count: 7'd64};
        vecs[2] = '{kind: 1, value: 128'd0, exp_data: 128'd2016, exp_count: 7'd64};
        vecs[3] = '{kind: 0, value: {WIDTH{1'b1}},
                    exp_data: 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFC0, exp_count: 7'd64};
        vecs[4] = '{kind: 0, value: 128'h00000000_00000001_00000000_00000000,
                    exp_data: 128'h00000000_00000040_00000000_00000000, exp_count: 7'd64};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset_out_valid", WIDTH'(out_valid), WIDTH'(0));
        checkOutput("reset_out_data", out_data, WIDTH'(0));
        checkOutput("reset_out_count", WIDTH'(out_count), WIDTH'(0));
        checkOutput("reset_in_ready", WIDTH'(in_ready), WIDTH'(1));
        checkOutput("reset_vec0", vec_out[0], WIDTH'(0));

        // Table of full batches
        out_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            sendBatch(vecs[v].kind, vecs[v].value, N, 1'b0, acc);
            finishBatch($sformatf("vec%0d", v), acc, vecs[v].exp_data, vecs[v].exp_count);
        end

        // Backpressure: result held, no word accepted while DONE
        out_ready = 1'b0;
        sendBatch(0, 128'd1, N, 1'b0, acc);
        waitOutValid(seen);
        checkOutput("bp_latency", WIDTH'(seen - acc), WIDTH'(7));
        in_valid = 1'b1;
        in_data  = 128'hAB;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checkOutput("bp_data_hold", out_data, WIDTH'(64));
            checkOutput("bp_count_hold", WIDTH'(out_count), WIDTH'(64));
            checkOutput("bp_valid_hold", WIDTH'(out_valid), WIDTH'(1));
            checkOutput("bp_in_ready", WIDTH'(in_ready), WIDTH'(0));
            checkOutput("bp_vec0_frozen", vec_out[0], WIDTH'(1));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_release_valid", WIDTH'(out_valid), WIDTH'(0));
        checkOutput("bp_release_vec0", vec_out[0], WIDTH'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("bp_first_word_slot", vec_out[0], WIDTH'(128'hAB));
        checkOutput("bp_second_slot_empty", vec_out[1], WIDTH'(0));
        sendBatch(0, 128'd1, N - 1, 1'b0, acc);
        finishBatch("bp_next", acc, WIDTH'(234), 7'd64);

        // Short batch 5, 6, 7 with in_last on the 7
        applyStimulus(128'd5, 1'b0, acc);
        applyStimulus(128'd6, 1'b0, acc);
        applyStimulus(128'd7, 1'b1, acc);
`ifdef FEEDER_ZERO_PAD_EN
        finishBatch("short", acc, WIDTH'(18), 7'd3);
        sendBatch(0, 128'd1, N, 1'b0, acc);
        finishBatch("short_after", acc, WIDTH'(64), 7'd64);
`else
        repeat (10) @(posedge clk);
        #1;
        checkOutput("short_stays_fill", WIDTH'(in_ready), WIDTH'(1));
        checkOutput("short_no_valid", WIDTH'(out_valid), WIDTH'(0));
        checkOutput("short_slot2", vec_out[2], WIDTH'(7));
        checkOutput("short_slot3", vec_out[3], WIDTH'(0));
        sendBatch(0, 128'd1, N - 3, 1'b0, acc);
        finishBatch("short_complete", acc, WIDTH'(79), 7'd64);
`endif

        // Reset asserted three cycles after the closing accept
        sendBatch(0, 128'd1, N, 1'b0, acc);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", WIDTH'(out_valid), WIDTH'(0));
        checkOutput("rst_out_data", out_data, WIDTH'(0));
        checkOutput("rst_out_count", WIDTH'(out_count), WIDTH'(0));
        checkOutput("rst_in_ready", WIDTH'(in_ready), WIDTH'(1));
        checkOutput("rst_vec0", vec_out[0], WIDTH'(0));
        checkOutput("rst_vec_last", vec_out[N-1], WIDTH'(0));
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) spurious++;
        end
        checkOutput("rst_no_spurious_valid", WIDTH'(spurious), WIDTH'(0));
        checkOutput("rst_idle_in_ready", WIDTH'(in_ready), WIDTH'(1));
        sendBatch(0, 128'd1, N, 1'b0, acc);
        finishBatch("rst_after", acc, WIDTH'(64), 7'd64);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
